// File: rtl/fir2_pair_serializer.sv
// fir2_pair_serializer: buffers (y2k, y2k_1) sample pairs from a two-phase
// polyphase FIR and emits them as one serial stream, y2k first, then y2k_1.
// The buffer is a DEPTH-entry pair FIFO. A one-bit phase selects which half
// of the head pair is being presented. The head entry pops only after its
// odd sample has been accepted downstream.
module fir2_pair_serializer #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,      // active-high asynchronous reset despite the name
    input  logic signed [DW-1:0] y2k,
    input  logic signed [DW-1:0] y2k_1,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic signed [DW-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_even,
    output logic [15:0]          sample_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Pair storage: even and odd halves kept side by side. No reset is needed.
    logic [DW-1:0] mem_even_q [DEPTH];
    logic [DW-1:0] mem_odd_q  [DEPTH];

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          phase_q, phase_d;
    logic [15:0]   sample_cnt_q, sample_cnt_d;

    logic          in_ready_s;
    logic          out_valid_s;
    logic          push_s;
    logic          xfer_s;
    logic          pop_s;
    logic [DW-1:0] out_data_s;

    assign in_ready_s  = (count_q < DEPTH_C);
    assign out_valid_s = (count_q != {CW{1'b0}});
    // A full buffer refuses the push even when it pops in the same cycle.
    assign push_s      = in_valid && in_ready_s;
    assign xfer_s      = out_valid_s && out_ready;
    assign pop_s       = xfer_s && phase_q;

    // Next-state logic for pointers, occupancy, phase and the transfer counter.
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        phase_d      = phase_q;
        sample_cnt_d = sample_cnt_q;

        if (push_s) begin
            tail_d = tail_q + AW'(1);
        end else begin
            tail_d = tail_q;
        end

        if (xfer_s) begin
            phase_d      = ~phase_q;
            sample_cnt_d = sample_cnt_q + 16'd1;
        end else begin
            phase_d      = phase_q;
            sample_cnt_d = sample_cnt_q;
        end

        if (pop_s) begin
            head_d = head_q + AW'(1);
        end else begin
            head_d = head_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers. Reset discards any buffered or half-emitted pair.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            head_q       <= {AW{1'b0}};
            tail_q       <= {AW{1'b0}};
            count_q      <= {CW{1'b0}};
            phase_q      <= 1'b0;
            sample_cnt_q <= 16'd0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            phase_q      <= phase_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end

    // Pair storage write at the tail on an accepted push.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_even_q[tail_q] <= y2k;
            mem_odd_q[tail_q]  <= y2k_1;
        end
    end

    // Select the current half of the head pair, forced to zero when nothing is valid.
    always_comb begin
        out_data_s = {DW{1'b0}};
        if (out_valid_s) begin
            if (phase_q) begin
                out_data_s = mem_odd_q[head_q];
            end else begin
                out_data_s = mem_even_q[head_q];
            end
        end else begin
            out_data_s = {DW{1'b0}};
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_s;
    assign out_data   = out_data_s;
    assign out_even   = out_valid_s & ~phase_q;
    assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_fir2_pair_serializer.sv
// Bench for fir2_pair_serializer. The reference model is a queue of the
// expected serial samples. Each accepted pair appends y2k, then y2k_1. Each
// downstream transfer removes the front sample. The number of pairs held is
// half the queue length, rounded up.
module tb_fir2_pair_serializer;

    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] y2k = '0;
    logic [DW-1:0] y2k_1 = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_even;
    logic [15:0]   sample_cnt;

    int            checks = 0;
    int            errors = 0;

    logic [DW-1:0] exp_q [$];
    logic [15:0]   m_cnt = 16'd0;
    int            pushes = 0;

    fir2_pair_serializer #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst),
        .y2k        (y2k),
        .y2k_1      (y2k_1),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_even   (out_even),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic logic m_ready();
        return ((exp_q.size() + 1) / 2) < DEPTH;
    endfunction

    function automatic logic m_valid();
        return exp_q.size() != 0;
    endfunction

    function automatic logic [DW-1:0] m_data();
        if (exp_q.size() == 0) return '0;
        return exp_q[0];
    endfunction

    function automatic logic m_even();
        return (exp_q.size() != 0) && ((exp_q.size() % 2) == 0);
    endfunction

    task automatic compare_all();
        chk("in_ready",   {31'd0, in_ready},  {31'd0, m_ready()});
        chk("out_valid",  {31'd0, out_valid}, {31'd0, m_valid()});
        chk("out_data",   {16'd0, out_data},  {16'd0, m_data()});
        chk("out_even",   {31'd0, out_even},  {31'd0, m_even()});
        chk("sample_cnt", {16'd0, sample_cnt}, {16'd0, m_cnt});
    endtask

    // One clock: drive at the current (post-negedge) time, update the model at
    // the rising edge, then compare at the next falling edge.
    task automatic step(input logic iv, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic ordy);
        logic do_push;
        logic do_xfer;
        in_valid  = iv;
        y2k       = a;
        y2k_1     = b;
        out_ready = ordy;
        do_push   = iv && m_ready();
        do_xfer   = m_valid() && ordy;
        @(posedge clk);
        if (do_xfer) begin
            void'(exp_q.pop_front());
            m_cnt = m_cnt + 16'd1;
        end
        if (do_push) begin
            exp_q.push_back(a);
            exp_q.push_back(b);
            pushes++;
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        m_cnt = 16'd0;
        @(negedge clk);
        rst = 1'b0;
        compare_all();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step(1'b0, '0, '0, 1'b1);
            n++;
        end
        chk(tag, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  {16'd0, out_data},  32'd0);
        chk("rst_out_even",  {31'd0, out_even},  32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_cnt",       {16'd0, sample_cnt}, 32'd0);
        do_reset();

        // Single pair
        step(1'b1, 16'h0003, 16'hFFFE, 1'b1);
        chk("single_y2k",   {16'd0, out_data}, 32'h0003);
        chk("single_even0", {31'd0, out_even}, 32'd1);
        step(1'b0, '0, '0, 1'b1);
        chk("single_y2k_1", {16'd0, out_data}, 32'hFFFE);
        chk("single_even1", {31'd0, out_even}, 32'd0);
        step(1'b0, '0, '0, 1'b1);
        chk("single_done",  {31'd0, out_valid}, 32'd0);
        chk("single_cnt",   {16'd0, sample_cnt}, 32'd2);

        // Fill to full with the consumer stalled
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 16'h0010 + 16'(i), 16'h0020 + 16'(i), 1'b0);
            if (i == 3) chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        end
        chk("full_hold", {16'd0, out_data}, 32'h0010);

        // Full, push offered together with phase-1 pop: pop only, then accept
        step(1'b1, 16'h0015, 16'h0025, 1'b1);
        chk("sim_ph0_ready", {31'd0, in_ready}, 32'd0);
        step(1'b1, 16'h0015, 16'h0025, 1'b1);
        chk("sim_pop_ready", {31'd0, in_ready}, 32'd1);
        chk("sim_head1",     {16'd0, out_data}, 32'h0011);
        step(1'b1, 16'h0015, 16'h0025, 1'b0);
        chk("sim_accepted",  {31'd0, in_ready}, 32'd0);
        drain("sim_drain");

        // Streaming: 100 random pairs with random handshakes
        do_reset();
        pushes = 0;
        for (int c = 0; c < 3000 && (pushes < 100 || exp_q.size() != 0); c++) begin
            step((pushes < 100) ? 1'($urandom_range(0, 1)) : 1'b0,
                 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end
        chk("stream_pairs", pushes, 32'd100);
        chk("stream_cnt",   {16'd0, sample_cnt}, 32'd200);

        // Reset in the middle of a pair
        step(1'b1, 16'h1234, 16'h5678, 1'b0);
        step(1'b0, '0, '0, 1'b1);
        chk("mid_odd_pending", {16'd0, out_data}, 32'h5678);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_cnt",   {16'd0, sample_cnt}, 32'd0);
        chk("mid_rst_data",  {16'd0, out_data},  32'd0);
        exp_q.delete();
        m_cnt = 16'd0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 16'h0ABC, 16'h0DEF, 1'b1);
        chk("mid_first_after", {16'd0, out_data}, 32'h0ABC);
        drain("mid_drain");

        // Counter wrap
        do_reset();
        for (int c = 0; c < 70000 && m_cnt != 16'hFFFF; c++) begin
            step(1'b1, 16'($urandom), 16'($urandom), 1'b1);
        end
        chk("wrap_ffff", {16'd0, sample_cnt}, 32'h0000FFFF);
        step(1'b1, 16'h0001, 16'h0002, 1'b1);
        chk("wrap_0000", {16'd0, sample_cnt}, 32'h00000000);
        step(1'b1, 16'h0003, 16'h0004, 1'b1);
        chk("wrap_0001", {16'd0, sample_cnt}, 32'h00000001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir2_pair_serializer.md
FIR2_PAIR_SERIALIZER -- requirements
Module: fir2_pair_serializer

Interface
REQ-001 The block SHALL have parameter DW, default 16, giving the signed sample width.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of sample-pair entries in the buffer; legal values are powers of two, 2..16.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-high (1 = reset asserted).
REQ-005 y2k  input  DW  signed even-phase FIR output, sample index 2k.
REQ-006 y2k_1  input  DW  signed odd-phase FIR output, sample index 2k+1.
REQ-007 in_valid  input  1  the y2k/y2k_1 pair is valid this cycle.
REQ-008 in_ready  output  1  the block can accept a pair this cycle.
REQ-009 out_data  output  DW  signed serial output sample.
REQ-010 out_valid  output  1  out_data is valid.
REQ-011 out_ready  input  1  the downstream consumer accepts out_data.
REQ-012 out_even  output  1  out_data is the 2k (even) sample of its pair.
REQ-013 sample_cnt  output  16  number of serial samples accepted downstream, modulo 2^16.

Function
REQ-014 Push: a pair SHALL be written to the tail of the FIFO on a rising edge where in_valid && in_ready.
REQ-015 in_ready SHALL be (count < DEPTH), where count is the number of occupied entries; in_ready SHALL NOT depend on out_ready.
REQ-016 When full, a pop and a push attempt in the same cycle SHALL result in a pop only; the pair offered on in_valid SHALL NOT be accepted in that cycle.
REQ-017 out_valid SHALL be (count != 0).
REQ-018 out_data SHALL be the head entry's y2k when phase = 0 and its y2k_1 when phase = 1; out_even SHALL equal ~phase while out_valid = 1, and 0 otherwise.
REQ-019 Serial handshake: a sample SHALL be transferred on a rising edge where out_valid && out_ready.
- Transfer with phase = 0: phase becomes 1; head is unchanged.
- Transfer with phase = 1: phase becomes 0; head pops, so count decrements unless a push occurs in the same cycle.
REQ-020 Simultaneous push and pop when not full SHALL leave count unchanged, with head and tail pointers both advancing.
REQ-021 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH, which requires log2(DEPTH)+1 bits.
REQ-022 Latency: a pair pushed into an empty FIFO at edge N SHALL present its y2k on out_data with out_valid = 1 in the cycle after edge N; its y2k_1 SHALL appear in the cycle after the first serial transfer.
REQ-023 Data SHALL pass bit-exact, with no rounding, saturation or sign change; output order SHALL be y2k then y2k_1 for each pair, in push order.
REQ-024 While out_valid = 1 and out_ready = 0, out_data and out_even SHALL hold stable.
REQ-025 sample_cnt SHALL increment by 1 on every serial transfer and wrap from 0xFFFF to 0x0000.
REQ-026 Throughput: sustained input SHALL be limited to one pair per two cycles; with out_ready held at 1, in_ready SHALL deassert only when count reaches DEPTH.

Reset
REQ-027 While rst_n = 1, independent of clk, the block SHALL force:
- count = 0, head = 0, tail = 0, phase = 0;
- sample_cnt = 0;
- out_valid = 0, out_even = 0, out_data = 0;
- in_ready = 1.
REQ-028 Reset asserted mid-operation SHALL discard all buffered pairs, including a half-emitted pair; the first output after reset release SHALL be the y2k of the first pair pushed after release.
REQ-029 FIFO storage contents need no reset, but out_data SHALL be gated to 0 whenever out_valid = 0.

Verification
REQ-030 The bench SHALL cover the single-pair case: with out_ready = 1, push (y2k = 0x0003, y2k_1 = 0xFFFE) -> the next cycle shows out_data 0x0003 with out_even = 1; the following cycle shows 0xFFFE with out_even = 0; out_valid = 0 after that; sample_cnt = 2.
REQ-031 The bench SHALL cover fill to full: with out_ready = 0, push 5 pairs back-to-back -> in_ready goes 0 after the 4th push; the 5th pair is not accepted; out_data holds the 1st y2k.
REQ-032 The bench SHALL cover simultaneous events: with the FIFO full, in_valid = 1, and out_ready = 1 on a phase = 1 transfer -> count goes 4 to 3 with no push; the pair is accepted on the next cycle.
REQ-033 The bench SHALL cover streaming: 100 random pairs with random in_valid and out_ready -> the serial stream equals the interleaved y2k, y2k_1 sequence exactly; sample_cnt = 200.
REQ-034 The bench SHALL cover reset mid-operation: assert rst_n after the y2k of a pair has been emitted -> out_valid = 0 and sample_cnt = 0 immediately; the pending y2k_1 is never emitted.
REQ-035 The bench SHALL cover counter wrap: preload via 65535 transfers, then 2 more transfers -> sample_cnt reads 0xFFFF, 0x0000, then 0x0001.
